// File: rtl/pong_game_engine.sv
// pong_game_engine
//   Game state and pixel colour generator, sitting directly upstream of the VGA
//   timing controller. Ball, paddles, scores and the SERVE/PLAY/POINT/OVER state
//   machine advance only in a cycle with frame_tick=1. The colour of the pixel
//   (pixel_x, pixel_y) is registered, so it appears one cycle later. In a tick
//   cycle the colour is rendered from the state as it was before that tick.
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   frame_tick                  one-cycle pulse per frame, during vertical blanking
//   pixel_x, pixel_y            current pixel from the timing stage
//   pixel_active                pixel lies in the visible region
//   btn_l_up/dn, btn_r_up/dn    debounced paddle buttons
//   red, green, blue            registered 4:4:4 pixel colour
//   score_l, score_r            player scores, saturating at MAX_SCORE
//   game_over                   high while the game is in OVER
module pong_game_engine #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_XL    = 16,
    parameter int PADDLE_XR    = 616,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int MAX_SCORE    = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       pixel_active,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);
    typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_t;

    localparam logic [9:0]        BALL_X0 = 10'(WIDTH/2 - BALL_SIZE/2);
    localparam logic [9:0]        BALL_Y0 = 10'(HEIGHT/2 - BALL_SIZE/2);
    localparam logic [9:0]        PAD_Y0  = 10'((HEIGHT - PADDLE_H)/2);
    localparam logic signed [10:0] S_BSPD = 11'(BALL_SPEED);
    localparam logic signed [10:0] S_PSPD = 11'(PADDLE_SPEED);
    localparam logic signed [10:0] S_PMAX = 11'(HEIGHT - PADDLE_H);
    localparam logic signed [10:0] S_YMAX = 11'(HEIGHT - BALL_SIZE);
    localparam logic signed [10:0] S_XMAX = 11'(WIDTH - BALL_SIZE);
    localparam logic signed [10:0] S_LHIT = 11'(PADDLE_XL + PADDLE_W);
    localparam logic signed [10:0] S_PXR  = 11'(PADDLE_XR);
    localparam logic signed [10:0] S_BS   = 11'(BALL_SIZE);
    localparam logic [9:0]        RHIT_X  = 10'(PADDLE_XR - BALL_SIZE);
    localparam logic [5:0]        SERVE_LAST = 6'(SERVE_FRAMES - 1);
    localparam logic [3:0]        SCORE_MAX  = 4'(MAX_SCORE);

    state_t     state, state_n;
    logic [5:0] serve_cnt, serve_n;
    logic [9:0] ball_x, ball_y, bx_n, by_n;
    logic       dx_neg, dy_neg, dx_n, dy_n;   // 1 = moving toward smaller coordinate
    logic [9:0] pl_y, pr_y, pl_n, pr_n;
    logic [3:0] sl_n, sr_n;

    logic signed [10:0] nx, ny;
    logic               ov_l, ov_r;

    // Next paddle row: 11-bit signed so the step above the top edge goes negative
    // instead of wrapping, then clamp to the playfield.
    function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up, input logic dn);
        logic signed [10:0] p;
        p = {1'b0, y};
        if (up && !dn)      p = p - S_PSPD;
        else if (dn && !up) p = p + S_PSPD;
        if (p < 11'sd0)      p = 11'sd0;
        else if (p > S_PMAX) p = S_PMAX;
        return p[9:0];
    endfunction

    always_comb begin
        state_n = state;
        serve_n = serve_cnt;
        bx_n    = ball_x;
        by_n    = ball_y;
        dx_n    = dx_neg;
        dy_n    = dy_neg;
        pl_n    = pl_y;
        pr_n    = pr_y;
        sl_n    = score_l;
        sr_n    = score_r;

        nx = dx_neg ? $signed({1'b0, ball_x}) - S_BSPD : $signed({1'b0, ball_x}) + S_BSPD;
        ny = dy_neg ? $signed({1'b0, ball_y}) - S_BSPD : $signed({1'b0, ball_y}) + S_BSPD;
        // Overlap is judged on the pre-tick ball row and paddle rows.
        ov_l = ({1'b0, ball_y} + 11'(BALL_SIZE) > {1'b0, pl_y}) &&
               ({1'b0, ball_y} < {1'b0, pl_y} + 11'(PADDLE_H));
        ov_r = ({1'b0, ball_y} + 11'(BALL_SIZE) > {1'b0, pr_y}) &&
               ({1'b0, ball_y} < {1'b0, pr_y} + 11'(PADDLE_H));

        if (state != OVER) begin
            pl_n = paddle_next(pl_y, btn_l_up, btn_l_dn);
            pr_n = paddle_next(pr_y, btn_r_up, btn_r_dn);
        end

        case (state)
            SERVE: begin
                if (serve_cnt == SERVE_LAST) begin
                    state_n = PLAY;
                    serve_n = '0;
                end else begin
                    serve_n = serve_cnt + 6'd1;
                end
            end
            PLAY: begin
                if (ny <= 11'sd0) begin
                    by_n = '0;
                    dy_n = 1'b0;
                end else if (ny >= S_YMAX) begin
                    by_n = S_YMAX[9:0];
                    dy_n = 1'b1;
                end else begin
                    by_n = ny[9:0];
                end
                // Paddle hits take precedence over misses. On a miss the ball is
                // parked on the edge it crossed until POINT recentres it.
                if (dx_neg && nx <= S_LHIT && ov_l) begin
                    bx_n = S_LHIT[9:0];
                    dx_n = 1'b0;
                end else if (!dx_neg && nx + S_BS >= S_PXR && ov_r) begin
                    bx_n = RHIT_X;
                    dx_n = 1'b1;
                end else if (nx <= 11'sd0) begin
                    bx_n    = '0;
                    sr_n    = (score_r == SCORE_MAX) ? score_r : score_r + 4'd1;
                    state_n = POINT;
                end else if (nx >= S_XMAX) begin
                    bx_n    = S_XMAX[9:0];
                    sl_n    = (score_l == SCORE_MAX) ? score_l : score_l + 4'd1;
                    state_n = POINT;
                end else begin
                    bx_n = nx[9:0];
                end
            end
            POINT: begin
                if (score_l == SCORE_MAX || score_r == SCORE_MAX) begin
                    state_n = OVER;
                end else begin
                    // dx is untouched by a miss, so it already points at the
                    // player who conceded.
                    bx_n    = BALL_X0;
                    by_n    = BALL_Y0;
                    dy_n    = 1'b0;
                    state_n = SERVE;
                end
            end
            OVER: begin
                if (btn_l_up || btn_l_dn || btn_r_up || btn_r_dn) begin
                    sl_n    = '0;
                    sr_n    = '0;
                    bx_n    = BALL_X0;
                    by_n    = BALL_Y0;
                    dx_n    = 1'b0;
                    dy_n    = 1'b0;
                    serve_n = '0;
                    state_n = SERVE;
                end
            end
            default: state_n = SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SERVE;
            serve_cnt <= '0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            pl_y      <= PAD_Y0;
            pr_y      <= PAD_Y0;
            score_l   <= '0;
            score_r   <= '0;
        end else if (frame_tick) begin
            state     <= state_n;
            serve_cnt <= serve_n;
            ball_x    <= bx_n;
            ball_y    <= by_n;
            dx_neg    <= dx_n;
            dy_neg    <= dy_n;
            pl_y      <= pl_n;
            pr_y      <= pr_n;
            score_l   <= sl_n;
            score_r   <= sr_n;
        end
    end

    assign game_over = (state == OVER);

    // Renderer: bounds inclusive at the low edge, exclusive at the high edge.
    logic [10:0] px, py;
    logic        hit_ball, hit_pad, hit_net;

    assign px = {1'b0, pixel_x};
    assign py = {1'b0, pixel_y};

    always_comb begin
        hit_ball = px >= {1'b0, ball_x} && px < {1'b0, ball_x} + 11'(BALL_SIZE) &&
                   py >= {1'b0, ball_y} && py < {1'b0, ball_y} + 11'(BALL_SIZE);
        hit_pad  = (px >= 11'(PADDLE_XL) && px < 11'(PADDLE_XL + PADDLE_W) &&
                    py >= {1'b0, pl_y} && py < {1'b0, pl_y} + 11'(PADDLE_H)) ||
                   (px >= 11'(PADDLE_XR) && px < 11'(PADDLE_XR + PADDLE_W) &&
                    py >= {1'b0, pr_y} && py < {1'b0, pr_y} + 11'(PADDLE_H));
        // Dashed centre net: 4 px wide, 8 rows on / 8 rows off.
        hit_net  = px >= 11'(WIDTH/2 - 2) && px <= 11'(WIDTH/2 + 1) && !pixel_y[3];
    end

    always_ff @(posedge clk) begin
        if (reset || !pixel_active)   {red, green, blue} <= 12'h000;
        else if (hit_ball || hit_pad) {red, green, blue} <= 12'hFFF;
        else if (hit_net)             {red, green, blue} <= 12'h888;
        else                          {red, green, blue} <= 12'h000;
    end
endmodule

// File: tb/tb_pong_game_engine.sv
// Bench for pong_game_engine: a constant render table, hand-written sequences
// for serve/launch, walls, a full idle game to OVER and restart, paddle limits,
// then randomized play checked against an integer reference model of the game.
module tb_pong_game_engine;
    logic       clk = 0, reset = 0, frame_tick = 0, pixel_active = 0;
    logic [9:0] pixel_x = 0, pixel_y = 0;
    logic       btn_l_up = 0, btn_l_dn = 0, btn_r_up = 0, btn_r_dn = 0;
    logic [3:0] red, green, blue, score_l, score_r;
    logic       game_over;

    int checks = 0, errors = 0;

    localparam int M_SERVE = 0, M_PLAY = 1, M_POINT = 2, M_OVER = 3;
    int m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_mode, m_serve;

    typedef struct {
        int          px;
        int          py;
        bit          act;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[16];

    pong_game_engine dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_active(pixel_active),
        .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
        .red(red), .green(green), .blue(blue),
        .score_l(score_l), .score_r(score_r), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
        m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0;
        m_mode = M_SERVE; m_serve = 0;
    endtask

    function automatic int move_paddle(int y, bit up, bit dn);
        int v;
        v = y + 4 * (int'(dn) - int'(up));
        if (v < 0) v = 0;
        if (v > 416) v = 416;
        return v;
    endfunction

    task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd);
        int  nx, ny;
        bit  ovl, ovr;
        ovl = (m_by + 8 > m_pl) && (m_by < m_pl + 64);
        ovr = (m_by + 8 > m_pr) && (m_by < m_pr + 64);
        if (m_mode != M_OVER) begin
            m_pl = move_paddle(m_pl, lu, ld);
            m_pr = move_paddle(m_pr, ru, rd);
        end
        case (m_mode)
            M_SERVE: begin
                if (m_serve == 59) begin m_mode = M_PLAY; m_serve = 0; end
                else m_serve++;
            end
            M_PLAY: begin
                nx = m_bx + 2 * m_dx;
                ny = m_by + 2 * m_dy;
                if (ny <= 0)        begin m_by = 0;   m_dy = 1;  end
                else if (ny >= 472) begin m_by = 472; m_dy = -1; end
                else m_by = ny;
                if (m_dx < 0 && nx <= 24 && ovl)           begin m_bx = 24;  m_dx = 1;  end
                else if (m_dx > 0 && nx + 8 >= 616 && ovr) begin m_bx = 608; m_dx = -1; end
                else if (nx <= 0)   begin m_bx = 0;   if (m_sr < 9) m_sr++; m_mode = M_POINT; end
                else if (nx >= 632) begin m_bx = 632; if (m_sl < 9) m_sl++; m_mode = M_POINT; end
                else m_bx = nx;
            end
            M_POINT: begin
                if (m_sl == 9 || m_sr == 9) m_mode = M_OVER;
                else begin m_bx = 316; m_by = 236; m_dy = 1; m_mode = M_SERVE; end
            end
            default: begin
                if (lu || ld || ru || rd) begin
                    m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
                    m_serve = 0; m_mode = M_SERVE;
                end
            end
        endcase
    endtask

    function automatic bit in_box(int px, int py, int x0, int y0, int w, int h);
        return px >= x0 && px < x0 + w && py >= y0 && py < y0 + h;
    endfunction

    function automatic logic [11:0] model_rgb(int px, int py, bit act);
        if (!act) return 12'h000;
        if (in_box(px, py, m_bx, m_by, 8, 8)) return 12'hFFF;
        if (in_box(px, py, 16, m_pl, 8, 64) || in_box(px, py, 616, m_pr, 8, 64)) return 12'hFFF;
        if (px >= 318 && px <= 321 && (py % 16) < 8) return 12'h888;
        return 12'h000;
    endfunction

    // ---------------- drivers ----------------
    task automatic step(input bit tick, input int px, input int py, input bit act,
                        output logic [11:0] rgb);
        @(negedge clk);
        frame_tick = tick; pixel_x = 10'(px); pixel_y = 10'(py); pixel_active = act;
        @(posedge clk); #1;
        // Move the pixel away so a colour that is not registered shows up wrong.
        frame_tick = 0; pixel_active = 0; pixel_x = 0; pixel_y = 0;
        #1 rgb = {red, green, blue};
    endtask

    function automatic int edge_of(int base, int size);
        int v;
        case ($urandom_range(0, 3))
            0: v = base - 1;
            1: v = base;
            2: v = base + size - 1;
            default: v = base + size;
        endcase
        return (v < 0) ? 0 : v;
    endfunction

    task automatic pick_pixel(output int px, output int py);
        case ($urandom_range(0, 4))
            0: begin px = $urandom_range(0, 639); py = $urandom_range(0, 479); end
            1: begin px = edge_of(m_bx, 8); py = edge_of(m_by, 8); end
            2: begin px = edge_of(16, 8);   py = edge_of(m_pl, 64); end
            3: begin px = edge_of(616, 8);  py = edge_of(m_pr, 64); end
            default: begin px = $urandom_range(316, 323); py = $urandom_range(0, 479); end
        endcase
    endtask

    task automatic probe(input string nm, input int px, input int py, input logic [11:0] exp);
        logic [11:0] got;
        step(1'b0, px, py, 1'b1, got);
        chk(nm, got, exp);
    endtask

    task automatic probe_model();
        int px, py;
        bit act;
        logic [11:0] got, exp;
        pick_pixel(px, py);
        act = ($urandom_range(0, 7) != 0);
        exp = model_rgb(px, py, act);
        step(1'b0, px, py, act, got);
        chk("render", got, exp);
    endtask

    task automatic do_tick();
        int px, py;
        logic [11:0] got, exp;
        pick_pixel(px, py);
        exp = model_rgb(px, py, 1'b1);   // pre-update state
        step(1'b1, px, py, 1'b1, got);
        chk("tick_render", got, exp);
        model_tick(btn_l_up, btn_l_dn, btn_r_up, btn_r_dn);
        chk("score_l", score_l, m_sl);
        chk("score_r", score_r, m_sr);
        chk("game_over", game_over, int'(m_mode == M_OVER));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; frame_tick = 0; pixel_active = 0;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    initial begin
        logic [11:0] got;

        // ---- reset state ----
        do_reset();
        step(1'b0, 320, 0, 1'b0, got);
        chk("reset_rgb", got, 12'h000);
        chk("reset_score_l", score_l, 0);
        chk("reset_score_r", score_r, 0);
        chk("reset_game_over", game_over, 0);

        // ---- render table at reset positions: ball (316,236), paddles y=208 ----
        vecs[0]  = '{320,   0, 1'b1, 12'h888};
        vecs[1]  = '{320,   8, 1'b1, 12'h000};
        vecs[2]  = '{321,  16, 1'b1, 12'h888};
        vecs[3]  = '{322,   0, 1'b1, 12'h000};
        vecs[4]  = '{316, 236, 1'b1, 12'hFFF};
        vecs[5]  = '{323, 243, 1'b1, 12'hFFF};
        vecs[6]  = '{324, 236, 1'b1, 12'h000};
        vecs[7]  = '{316, 244, 1'b1, 12'h000};
        vecs[8]  = '{318, 240, 1'b1, 12'hFFF};
        vecs[9]  = '{ 16, 208, 1'b1, 12'hFFF};
        vecs[10] = '{ 23, 271, 1'b1, 12'hFFF};
        vecs[11] = '{ 24, 208, 1'b1, 12'h000};
        vecs[12] = '{ 16, 272, 1'b1, 12'h000};
        vecs[13] = '{616, 208, 1'b1, 12'hFFF};
        vecs[14] = '{615, 208, 1'b1, 12'h000};
        vecs[15] = '{320,   0, 1'b0, 12'h000};
        for (int i = 0; i < 16; i++) begin
            step(1'b0, vecs[i].px, vecs[i].py, vecs[i].act, got);
            if (got !== vecs[i].exp) begin
                errors++;
                $display("FAIL render_vec%0d (%0d,%0d) got %0h expected %0h",
                         i, vecs[i].px, vecs[i].py, got, vecs[i].exp);
            end
            checks++;
        end

        // ---- idle game: serve, launch, bottom wall, nine right-side misses ----
        for (int t = 1; t <= 1971; t++) begin
            do_tick();
            if (t == 60) probe("held_at_centre", 316, 236, 12'hFFF);
            if (t == 61) begin
                probe("launch_ball", 318, 238, 12'hFFF);
                probe("launch_left_of_ball", 317, 238, 12'h000);
                probe("launch_far_corner", 325, 245, 12'hFFF);
            end
            if (t == 178) begin
                probe("bottom_wall_ball", 552, 472, 12'hFFF);
                probe("bottom_wall_above", 552, 471, 12'h000);
            end
            if (t == 179) probe("bottom_wall_rebound", 554, 470, 12'hFFF);
            if (t == 217) chk("before_first_point", score_l, 0);
            if (t == 218) chk("first_point", score_l, 1);
            if (t == 1970) begin
                chk("ninth_point", score_l, 9);
                chk("not_over_yet", game_over, 0);
            end
            if (t == 1971) chk("over", game_over, 1);
        end
        for (int t = 0; t < 3; t++) do_tick();
        chk("over_holds", game_over, 1);
        btn_r_dn = 1;
        do_tick();
        btn_r_dn = 0;
        chk("restart_score_l", score_l, 0);
        chk("restart_game_over", game_over, 0);
        probe("restart_centre", 316, 236, 12'hFFF);

        // ---- paddle travel and clamp ----
        do_reset();
        btn_l_up = 1;
        for (int t = 1; t <= 60; t++) begin
            do_tick();
            if (t == 51) begin
                probe("paddle_t51_top", 16, 4, 12'hFFF);
                probe("paddle_t51_above", 16, 3, 12'h000);
            end
            if (t == 52) probe("paddle_t52_zero", 16, 0, 12'hFFF);
        end
        probe("paddle_clamped_top", 16, 0, 12'hFFF);
        probe("paddle_clamped_bottom", 16, 64, 12'h000);
        btn_l_up = 0;

        do_reset();
        btn_l_up = 1; btn_l_dn = 1; btn_r_up = 1;
        for (int t = 0; t < 10; t++) do_tick();
        btn_l_up = 0; btn_l_dn = 0; btn_r_up = 0;
        probe("both_buttons_hold", 16, 208, 12'hFFF);
        probe("both_buttons_above", 16, 207, 12'h000);
        probe("right_up_moved", 616, 168, 12'hFFF);
        probe("right_up_above", 616, 167, 12'h000);

        // ---- randomized play against the model ----
        do_reset();
        for (int t = 0; t < 4000; t++) begin
            int n;
            if (t % 16 == 0) begin
                btn_l_up = 1'($urandom_range(0, 1));
                btn_l_dn = 1'($urandom_range(0, 1));
                btn_r_up = 1'($urandom_range(0, 1));
                btn_r_dn = 1'($urandom_range(0, 1));
            end
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) probe_model();
            do_tick();
        end
        btn_l_up = 0; btn_l_dn = 0; btn_r_up = 0; btn_r_dn = 0;

        // ---- reset in the middle of a frame, ahead of a tick ----
        @(negedge clk);
        reset = 1; frame_tick = 1; pixel_active = 1;
        pixel_x = 10'(m_bx); pixel_y = 10'(m_by);
        @(posedge clk); #1;
        chk("midreset_rgb", {red, green, blue}, 12'h000);
        chk("midreset_score_l", score_l, 0);
        chk("midreset_score_r", score_r, 0);
        chk("midreset_game_over", game_over, 0);
        @(negedge clk);
        reset = 0; frame_tick = 0; pixel_active = 0;
        model_reset();
        probe("midreset_ball", 316, 236, 12'hFFF);
        probe("midreset_paddle", 16, 208, 12'hFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
